idecoder_pipe: RTL and testbench
================================

# idecoder_pipe

Registered, flow-controlled RV32I instruction decoder sitting between fetch and the register-read/execute stage. It accepts one instruction word and its PC per handshake, decodes every RV32I base opcode class into opcode, immediate, type, register indices and function code, and presents the result one cycle later. A two-entry skid buffer gives full throughput with a registered `in_ready`. A synchronous flush is provided for branch redirects.

## Interface
- `inst_width`, 32: instruction word width.
- `pc_width`, 32: PC width carried alongside the instruction.
- `imm_width`, 32: sign-extended immediate width.
- `reg_width`, 5: register index width.
- `funct_width`, 4: function code width; bit 3 is the inst[30] modifier, bits 2:0 are funct3.
- `clk` input 1: single clock; all state on its rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous; discards all buffered entries.
- `in_valid` input 1: the input word is valid.
- `in_ready` output 1: the decoder can accept a word.
- `in_inst` input `inst_width`: instruction word.
- `in_pc` input `pc_width`: PC of `in_inst`.
- `out_valid` output 1: decoded entry valid.
- `out_ready` input 1: consumer accepts the entry.
- `out_opcode` output 7: inst[6:0].
- `out_imm` output `imm_width`: decoded immediate.
- `out_inst_type` output `INST_TYPE_WIDTH` (=4): instruction class.
- `out_rd`, `out_rs1`, `out_rs2` output `reg_width`: register indices, 0 when unused.
- `out_funct` output `funct_width`: function code.
- `out_pc` output `pc_width`: PC of the entry.
- `out_illegal` output 1: the entry is an illegal encoding.

## Operation
- Type codes are defined in the shared defines header:
  - NONE=0, IMM(LUI)=1, INT_IMM=2, INT_REG=3, BRANCH=4, AUIPC=5, JAL=6, JALR=7, LOAD=8, STORE=9.
- Decode is combinational on `in_inst`. The result is captured with the handshake, and all unused fields are 0.
- LUI 0x37, AUIPC 0x17:
  - imm={inst[31:12],12'b0}; rd.
- JAL 0x6F:
  - imm = sign-extended {inst[31],inst[19:12],inst[20],inst[30:21],0}; rd.
- JALR 0x67, LOAD 0x03:
  - imm = sign-extended inst[31:20]; rd, rs1; funct={0,funct3}.
- OP-IMM 0x13:
  - Same fields as JALR/LOAD.
  - For funct3=101, funct[3]=inst[30].
- OP 0x33:
  - rd, rs1, rs2.
  - funct[3]=1 only when funct7=0100000.
- BRANCH 0x63:
  - imm = sign-extended {inst[31],inst[7],inst[30:25],inst[11:8],0}; rs1, rs2; funct={0,funct3}.
- STORE 0x23:
  - imm = sign-extended {inst[31:25],inst[11:7]}; rs1, rs2; funct={0,funct3}.
- Any other opcode decodes to type NONE with all fields 0.
- Buffer: an output register plus one skid register, with occupancy 0/1/2.
  - Accept when `in_valid & in_ready`.
  - Retire when `out_valid & out_ready`.
  - Entries leave in arrival order.
  - `in_ready` = skid register empty. It is driven directly from a flop.
  - Accept while full cannot occur.
- Occupancy transitions:
  - 0 → 1 on accept.
  - 1 → 1 on accept plus retire.
  - 1 → 2 on accept with no retire; the new entry goes to skid.
  - 2 → 1 on retire; the skid entry moves to output.
  - 1 → 0 on retire with no accept.
- `flush` has priority over everything else:
  - Occupancy goes to 0 and any same-cycle input is dropped.
  - A same-cycle retire still completes at the consumer.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, all data outputs 0, `out_illegal`=0.
- Reset is honoured asynchronously mid-stream; buffered entries are lost.
- Latency: an accept at edge N gives `out_valid` high after edge N.
- Throughput: 1 instruction per cycle while `out_ready`=1.
- Outputs are held stable while `out_valid & ~out_ready`.
- `in_ready` falls the cycle after a second entry is buffered, and rises the cycle after a retire from occupancy 2.
- After `flush` at edge N: `out_valid`=0 and `in_ready`=1 from edge N.

## Configuration
- `IDECODER_ILLEGAL_EN` defined:
  - These encodings set `out_illegal`=1 with type NONE:
    - inst[1:0]≠11.
    - An unlisted opcode.
    - OP with funct7 ∉ {0000000, 0100000}, or funct7=0100000 with funct3 ∉ {000, 101}.
    - OP-IMM shift (funct3 001/101) with a bad funct7.
    - BRANCH funct3 010/011.
    - JALR funct3≠0.
  - The entry still flows through the buffer normally.
- Not defined: `out_illegal` is tied 0 and no legality logic is built.

## Test plan
- LUI 0x123450B7 → type 1, rd=1, imm=0x12345000, rs1=rs2=0, out_valid 1 cycle after accept.
- ADDI 0xFFF08113 → type 2, rd=2, rs1=1, imm=0xFFFFFFFF, funct=0.
- SUB 0x402081B3 → type 3, rd=3, rs1=1, rs2=2, funct=4'b1000. Same word with funct7=0x00 → funct=0.
- BEQ 0xFE000EE3 → type 4, imm=0xFFFFFFFC, rs1=rs2=0.
- Stream 6 words (PC 0,4,…,20) with `out_ready` low for cycles 2–4:
  - `in_ready` drops after the 2nd buffered entry.
  - No loss or duplication; PCs emerge in order.
  - Full rate resumes.
- Two entries buffered, then `flush` together with `in_valid` → `out_valid`=0 next cycle, the input word is never emitted, `in_ready`=1.
- With `IDECODER_ILLEGAL_EN`: 0x00000000 → out_illegal=1, type 0. Without it: out_illegal=0.

Source files
------------

// File: rtl/idecoder_pipe_if.sv
// idecoder_pipe_if: handshake and payload bundle around idecoder_pipe.
// master = fetch/consumer side, slave = the decoder.

interface idecoder_pipe_if #(
    parameter int INST_WIDTH      = 32,
    parameter int PC_WIDTH        = 32,
    parameter int IMM_WIDTH       = 32,
    parameter int REG_WIDTH       = 5,
    parameter int FUNCT_WIDTH     = 4,
    parameter int INST_TYPE_WIDTH = 4
);

    logic                       flush;
    logic                       in_valid;
    logic                       in_ready;
    logic [INST_WIDTH-1:0]      in_inst;
    logic [PC_WIDTH-1:0]        in_pc;
    logic                       out_valid;
    logic                       out_ready;
    logic [6:0]                 out_opcode;
    logic [IMM_WIDTH-1:0]       out_imm;
    logic [INST_TYPE_WIDTH-1:0] out_inst_type;
    logic [REG_WIDTH-1:0]       out_rd;
    logic [REG_WIDTH-1:0]       out_rs1;
    logic [REG_WIDTH-1:0]       out_rs2;
    logic [FUNCT_WIDTH-1:0]     out_funct;
    logic [PC_WIDTH-1:0]        out_pc;
    logic                       out_illegal;

    modport master (
        output flush, in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_opcode, out_imm, out_inst_type,
               out_rd, out_rs1, out_rs2, out_funct, out_pc, out_illegal
    );

    modport slave (
        input  flush, in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_opcode, out_imm, out_inst_type,
               out_rd, out_rs1, out_rs2, out_funct, out_pc, out_illegal
    );

endinterface

// File: rtl/idecoder_pipe.sv
// idecoder_pipe: registered, flow-controlled RV32I instruction decoder.
// Decodes one instruction word per handshake into opcode, immediate, class,
// register indices and function code. A two-entry buffer (output register
// plus skid register) sustains one word per cycle with a registered in_ready.
// Optional feature macro: IDECODER_ILLEGAL_EN builds the illegal-encoding
// checker. Without it, out_illegal is tied to 0.

package idecoder_pkg;

    localparam int INST_TYPE_WIDTH = 4;

    // Instruction class codes presented on out_inst_type
    typedef enum logic [INST_TYPE_WIDTH-1:0] {
        TYPE_NONE    = 4'd0,
        TYPE_IMM     = 4'd1,
        TYPE_INT_IMM = 4'd2,
        TYPE_INT_REG = 4'd3,
        TYPE_BRANCH  = 4'd4,
        TYPE_AUIPC   = 4'd5,
        TYPE_JAL     = 4'd6,
        TYPE_JALR    = 4'd7,
        TYPE_LOAD    = 4'd8,
        TYPE_STORE   = 4'd9
    } inst_type_e;

    // RV32I base opcodes
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_BRANCH = 7'h63;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // One decoded instruction, excluding its PC
    typedef struct packed {
        logic [6:0]  opcode;
        logic [31:0] imm;
        inst_type_e  itype;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [3:0]  funct;
        logic        illegal;
    } dec_t;

endpackage

module idecoder_pipe
    import idecoder_pkg::*;
#(
    // Must match the PC_WIDTH of the connected idecoder_pipe_if
    parameter int PC_WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    idecoder_pipe_if.slave    bus
);

    // ------------------------------------------------------------------
    // Combinational decode of the incoming word
    // ------------------------------------------------------------------
    logic [31:0] w_inst;
    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    dec_t        w_raw;
    dec_t        w_dec;

    assign w_inst   = bus.in_inst;
    assign w_opcode = w_inst[6:0];
    assign w_f3     = w_inst[14:12];
    assign w_f7     = w_inst[31:25];

    assign w_imm_i = {{20{w_inst[31]}}, w_inst[31:20]};
    assign w_imm_s = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
    assign w_imm_b = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
    assign w_imm_u = {w_inst[31:12], 12'b0};
    assign w_imm_j = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};

    // Field extraction per opcode class; unused fields stay 0
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_raw        = '0;
        w_raw.opcode = w_opcode;
        w_raw.itype  = TYPE_NONE;
        case (w_opcode)
            OPC_LUI: begin
                w_raw.itype = TYPE_IMM;
                w_raw.imm   = w_imm_u;
                w_raw.rd    = w_inst[11:7];
            end
            OPC_AUIPC: begin
                w_raw.itype = TYPE_AUIPC;
                w_raw.imm   = w_imm_u;
                w_raw.rd    = w_inst[11:7];
            end
            OPC_JAL: begin
                w_raw.itype = TYPE_JAL;
                w_raw.imm   = w_imm_j;
                w_raw.rd    = w_inst[11:7];
            end
            OPC_JALR: begin
                w_raw.itype = TYPE_JALR;
                w_raw.imm   = w_imm_i;
                w_raw.rd    = w_inst[11:7];
                w_raw.rs1   = w_inst[19:15];
                w_raw.funct = {1'b0, w_f3};
            end
            OPC_LOAD: begin
                w_raw.itype = TYPE_LOAD;
                w_raw.imm   = w_imm_i;
                w_raw.rd    = w_inst[11:7];
                w_raw.rs1   = w_inst[19:15];
                w_raw.funct = {1'b0, w_f3};
            end
            OPC_OP_IMM: begin
                // inst[30] distinguishes SRAI from SRLI only for funct3=101
                w_raw.itype = TYPE_INT_IMM;
                w_raw.imm   = w_imm_i;
                w_raw.rd    = w_inst[11:7];
                w_raw.rs1   = w_inst[19:15];
                w_raw.funct = {(w_f3 == 3'b101) & w_inst[30], w_f3};
            end
            OPC_OP: begin
                w_raw.itype = TYPE_INT_REG;
                w_raw.rd    = w_inst[11:7];
                w_raw.rs1   = w_inst[19:15];
                w_raw.rs2   = w_inst[24:20];
                w_raw.funct = {(w_f7 == F7_ALT), w_f3};
            end
            OPC_BRANCH: begin
                w_raw.itype = TYPE_BRANCH;
                w_raw.imm   = w_imm_b;
                w_raw.rs1   = w_inst[19:15];
                w_raw.rs2   = w_inst[24:20];
                w_raw.funct = {1'b0, w_f3};
            end
            OPC_STORE: begin
                w_raw.itype = TYPE_STORE;
                w_raw.imm   = w_imm_s;
                w_raw.rs1   = w_inst[19:15];
                w_raw.rs2   = w_inst[24:20];
                w_raw.funct = {1'b0, w_f3};
            end
            default: begin
                w_raw.itype = TYPE_NONE;
            end
        endcase
    end

`ifdef IDECODER_ILLEGAL_EN
    logic w_illegal;

    // Flag encodings outside the RV32I base set
    always_comb begin
        w_illegal = 1'b0;
        if (w_inst[1:0] != 2'b11) begin
            w_illegal = 1'b1;
        end else begin
            case (w_opcode)
                OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_LOAD, OPC_STORE: begin
                    w_illegal = 1'b0;
                end
                OPC_JALR: begin
                    w_illegal = (w_f3 != 3'b000);
                end
                OPC_OP: begin
                    if (w_f7 == F7_ZERO) begin
                        w_illegal = 1'b0;
                    end else if (w_f7 == F7_ALT) begin
                        w_illegal = !((w_f3 == 3'b000) || (w_f3 == 3'b101));
                    end else begin
                        w_illegal = 1'b1;
                    end
                end
                OPC_OP_IMM: begin
                    // Shifts reuse imm[11:5] as funct7
                    if (w_f3 == 3'b001) begin
                        w_illegal = (w_f7 != F7_ZERO);
                    end else if (w_f3 == 3'b101) begin
                        w_illegal = !((w_f7 == F7_ZERO) || (w_f7 == F7_ALT));
                    end else begin
                        w_illegal = 1'b0;
                    end
                end
                OPC_BRANCH: begin
                    w_illegal = (w_f3 == 3'b010) || (w_f3 == 3'b011);
                end
                default: begin
                    w_illegal = 1'b1;
                end
            endcase
        end
    end

    // Illegal words carry only the raw opcode and the illegal flag
    always_comb begin
        w_dec = w_raw;
        if (w_illegal) begin
            w_dec         = '0;
            w_dec.opcode  = w_opcode;
            w_dec.itype   = TYPE_NONE;
            w_dec.illegal = 1'b1;
        end
    end
`else
    assign w_dec = w_raw;
`endif

    // ------------------------------------------------------------------
    // Two-entry buffer: output register plus skid register
    // ------------------------------------------------------------------
    dec_t                r_out_dec;
    logic [PC_WIDTH-1:0] r_out_pc;
    logic                r_out_valid;
    dec_t                r_skid_dec;
    logic [PC_WIDTH-1:0] r_skid_pc;
    logic                r_skid_valid;
    logic                r_in_ready;

    logic w_accept;
    logic w_retire;
    logic w_out_valid_nxt;
    logic w_skid_valid_nxt;
    logic w_load_out_in;
    logic w_load_out_skid;
    logic w_load_skid;

    assign w_accept = bus.in_valid & r_in_ready;
    assign w_retire = r_out_valid & bus.out_ready;

    // Occupancy transitions and data-move selects; flush overrides all
    always_comb begin
        w_out_valid_nxt  = r_out_valid;
        w_skid_valid_nxt = r_skid_valid;
        w_load_out_in    = 1'b0;
        w_load_out_skid  = 1'b0;
        w_load_skid      = 1'b0;
        if (bus.flush) begin
            w_out_valid_nxt  = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (r_skid_valid) begin
            // Full: in_ready is low, so only a retire can happen
            if (w_retire) begin
                w_load_out_skid  = 1'b1;
                w_skid_valid_nxt = 1'b0;
            end
        end else if (r_out_valid) begin
            if (w_accept && w_retire) begin
                w_load_out_in = 1'b1;
            end else if (w_accept) begin
                w_load_skid      = 1'b1;
                w_skid_valid_nxt = 1'b1;
            end else if (w_retire) begin
                w_out_valid_nxt = 1'b0;
            end
        end else if (w_accept) begin
            w_load_out_in   = 1'b1;
            w_out_valid_nxt = 1'b1;
        end
    end

    // Valid flags and the registered in_ready
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            // NOTE: state uses non-blocking assignments so every flop samples
            // pre-edge values regardless of statement order.
            r_out_valid  <= w_out_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_in_ready   <= ~w_skid_valid_nxt;
        end
    end

    // Payload registers; output and skid data move only on their load selects
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: payload registers are reset because the data outputs must
            // read 0 out of reset, not merely be qualified by out_valid.
            r_out_dec  <= '0;
            r_out_pc   <= '0;
            r_skid_dec <= '0;
            r_skid_pc  <= '0;
        end else begin
            if (w_load_out_in) begin
                r_out_dec <= w_dec;
                r_out_pc  <= bus.in_pc;
            end else if (w_load_out_skid) begin
                r_out_dec <= r_skid_dec;
                r_out_pc  <= r_skid_pc;
            end
            if (w_load_skid) begin
                r_skid_dec <= w_dec;
                r_skid_pc  <= bus.in_pc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs straight from flops
    // ------------------------------------------------------------------
    assign bus.in_ready      = r_in_ready;
    assign bus.out_valid     = r_out_valid;
    assign bus.out_opcode    = r_out_dec.opcode;
    assign bus.out_imm       = r_out_dec.imm;
    assign bus.out_inst_type = r_out_dec.itype;
    assign bus.out_rd        = r_out_dec.rd;
    assign bus.out_rs1       = r_out_dec.rs1;
    assign bus.out_rs2       = r_out_dec.rs2;
    assign bus.out_funct     = r_out_dec.funct;
    assign bus.out_pc        = r_out_pc;
    assign bus.out_illegal   = r_out_dec.illegal;

endmodule

// File: tb/tb_idecoder_pipe.sv
// tb_idecoder_pipe: directed, table-driven bench for idecoder_pipe.
// Decode vectors are applied one per transaction; stall, flush and reset
// corner cases are hand-written sequences.

module tb_idecoder_pipe;

    logic clk;
    logic rst;

    idecoder_pipe_if bus ();

    idecoder_pipe u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef IDECODER_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] inst;
        logic [6:0]  opcode;
        logic [3:0]  itype;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [3:0]  funct;
        logic        illegal;
        logic        full;    // compare every field, not just type/illegal
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [31:0] inst, input logic [6:0] opc,
                                 input logic [3:0] t, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [31:0] imm, input logic [3:0] f,
                                 input logic ill, input logic full);
        vec_t v;
        v.inst = inst; v.opcode = opc; v.itype = t; v.rd = rd; v.rs1 = rs1;
        v.rs2 = rs2; v.imm = imm; v.funct = f; v.illegal = ill; v.full = full;
        return v;
    endfunction

    // ADDI rd, x0, 0 carrying a tag in rd so payload movement is visible
    function automatic logic [31:0] addi_rd(input int rd);
        logic [4:0] r;
        r = rd[4:0];
        return {12'h000, 5'd0, 3'b000, r, 7'h13};
    endfunction

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   q[$];
        int   cyc;
        int   sent;
        int   got;
        bit   acc;
        bit   ret;

        // Decode vectors with hand-computed expectations
        vecs[0]  = mkv(32'h123450B7, 7'h37, 4'd1, 5'd1, 5'd0, 5'd0, 32'h12345000, 4'h0, 1'b0, 1'b1); // LUI
        vecs[1]  = mkv(32'hFFF08113, 7'h13, 4'd2, 5'd2, 5'd1, 5'd0, 32'hFFFFFFFF, 4'h0, 1'b0, 1'b1); // ADDI -1
        vecs[2]  = mkv(32'h402081B3, 7'h33, 4'd3, 5'd3, 5'd1, 5'd2, 32'h00000000, 4'h8, 1'b0, 1'b1); // SUB
        vecs[3]  = mkv(32'h002081B3, 7'h33, 4'd3, 5'd3, 5'd1, 5'd2, 32'h00000000, 4'h0, 1'b0, 1'b1); // ADD
        vecs[4]  = mkv(32'hFE000EE3, 7'h63, 4'd4, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 4'h0, 1'b0, 1'b1); // BEQ -4
        vecs[5]  = mkv(32'h0020A423, 7'h23, 4'd9, 5'd0, 5'd1, 5'd2, 32'h00000008, 4'h2, 1'b0, 1'b1); // SW
        vecs[6]  = mkv(32'hFFDFF0EF, 7'h6F, 4'd6, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFC, 4'h0, 1'b0, 1'b1); // JAL -4
        vecs[7]  = mkv(32'h004280E7, 7'h67, 4'd7, 5'd1, 5'd5, 5'd0, 32'h00000004, 4'h0, 1'b0, 1'b1); // JALR
        vecs[8]  = mkv(32'hFF812183, 7'h03, 4'd8, 5'd3, 5'd2, 5'd0, 32'hFFFFFFF8, 4'h2, 1'b0, 1'b1); // LW -8
        vecs[9]  = mkv(32'hFFFFF297, 7'h17, 4'd5, 5'd5, 5'd0, 5'd0, 32'hFFFFF000, 4'h0, 1'b0, 1'b1); // AUIPC
        vecs[10] = mkv(32'h40315093, 7'h13, 4'd2, 5'd1, 5'd2, 5'd0, 32'h00000403, 4'hD, 1'b0, 1'b1); // SRAI
        vecs[11] = mkv(32'h00000000, 7'h00, 4'd0, 5'd0, 5'd0, 5'd0, 32'h00000000, 4'h0, ILL_EN, 1'b1); // all-zero word
        vecs[12] = mkv(32'h0020C463, 7'h63, 4'd4, 5'd0, 5'd1, 5'd2, 32'h00000008, 4'h4, 1'b0, 1'b1); // BLT +8
        if (ILL_EN)
            vecs[13] = mkv(32'h0020A463, 7'h63, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0, 4'h0, 1'b1, 1'b0);   // BRANCH f3=010
        else
            vecs[13] = mkv(32'h0020A463, 7'h63, 4'd4, 5'd0, 5'd1, 5'd2, 32'h00000008, 4'h2, 1'b0, 1'b1);

        // Reset
        rst           = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_inst   = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset in_ready",  32'(bus.in_ready),      32'd1);
        check("reset out_valid", 32'(bus.out_valid),     32'd0);
        check("reset out_imm",   bus.out_imm,            32'd0);
        check("reset out_pc",    bus.out_pc,             32'd0);
        check("reset out_type",  32'(bus.out_inst_type), 32'd0);
        check("reset illegal",   32'(bus.out_illegal),   32'd0);
        rst = 1'b1;

        // Table-driven decode: one word per transaction, checked one cycle later
        for (int i = 0; i < NVEC; i++) begin
            v = vecs[i];
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_inst  = v.inst;
            bus.in_pc    = 32'(i * 4 + 32'h1000);
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
            @(negedge clk);
            check($sformatf("vec%0d out_valid", i), 32'(bus.out_valid),     32'd1);
            check($sformatf("vec%0d type", i),      32'(bus.out_inst_type), 32'(v.itype));
            check($sformatf("vec%0d illegal", i),   32'(bus.out_illegal),   32'(v.illegal));
            check($sformatf("vec%0d pc", i),        bus.out_pc,             32'(i * 4 + 32'h1000));
            if (v.full) begin
                check($sformatf("vec%0d opcode", i), 32'(bus.out_opcode), 32'(v.opcode));
                check($sformatf("vec%0d rd", i),     32'(bus.out_rd),     32'(v.rd));
                check($sformatf("vec%0d rs1", i),    32'(bus.out_rs1),    32'(v.rs1));
                check($sformatf("vec%0d rs2", i),    32'(bus.out_rs2),    32'(v.rs2));
                check($sformatf("vec%0d imm", i),    bus.out_imm,         v.imm);
                check($sformatf("vec%0d funct", i),  32'(bus.out_funct),  32'(v.funct));
            end
        end
        @(negedge clk);
        check("drain out_valid", 32'(bus.out_valid), 32'd0);

        // Stream 6 words, consumer stalled in cycles 2..4; occupancy model
        q.delete();
        cyc  = 0;
        sent = 0;
        got  = 0;
        while (got < 6 && cyc < 40) begin
            @(negedge clk);
            check($sformatf("stream c%0d in_ready", cyc),  32'(bus.in_ready),  32'(q.size() < 2));
            check($sformatf("stream c%0d out_valid", cyc), 32'(bus.out_valid), 32'(q.size() > 0));
            if (q.size() > 0) begin
                check($sformatf("stream c%0d out_pc", cyc), bus.out_pc,          32'(q[0]));
                check($sformatf("stream c%0d out_rd", cyc), 32'(bus.out_rd),     32'(q[0] / 4 + 1));
            end
            bus.in_valid  = (sent < 6);
            bus.in_inst   = addi_rd(sent + 1);
            bus.in_pc     = 32'(sent * 4);
            bus.out_ready = !(cyc >= 2 && cyc <= 4);
            acc = bus.in_valid && (q.size() < 2);
            ret = bus.out_ready && (q.size() > 0);
            @(posedge clk);
            if (ret) begin
                void'(q.pop_front());
                got++;
            end
            if (acc) begin
                q.push_back(sent * 4);
                sent++;
            end
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("stream retired count", 32'(got), 32'd6);
        check("stream cycle count",   32'(cyc), 32'd10);

        // Flush with two entries buffered and a word offered
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_inst   = addi_rd(10);
        bus.in_pc     = 32'h100;
        @(negedge clk);
        bus.in_inst   = addi_rd(11);
        bus.in_pc     = 32'h104;
        @(negedge clk);
        check("full in_ready",  32'(bus.in_ready),  32'd0);
        check("full out_valid", 32'(bus.out_valid), 32'd1);
        check("full out_pc",    bus.out_pc,         32'h100);
        bus.flush    = 1'b1;
        bus.in_inst  = addi_rd(12);
        bus.in_pc    = 32'h108;
        @(negedge clk);
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("flush2 out_valid", 32'(bus.out_valid), 32'd0);
        check("flush2 in_ready",  32'(bus.in_ready),  32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("flush2 idle%0d out_valid", k), 32'(bus.out_valid), 32'd0);
        end

        // Flush at occupancy 1 with a retire and an acceptable word in the same cycle
        bus.in_valid = 1'b1;
        bus.in_inst  = addi_rd(13);
        bus.in_pc    = 32'h200;
        @(negedge clk);
        check("flush1 pre out_valid", 32'(bus.out_valid), 32'd1);
        check("flush1 pre out_pc",    bus.out_pc,         32'h200);
        bus.flush   = 1'b1;
        bus.in_inst = addi_rd(14);
        bus.in_pc   = 32'h204;
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("flush1 out_valid", 32'(bus.out_valid), 32'd0);
        check("flush1 in_ready",  32'(bus.in_ready),  32'd1);
        @(negedge clk);
        check("flush1 dropped out_valid", 32'(bus.out_valid), 32'd0);

        // Recovery after flush
        bus.in_valid = 1'b1;
        bus.in_inst  = addi_rd(15);
        bus.in_pc    = 32'h300;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("recover out_valid", 32'(bus.out_valid), 32'd1);
        check("recover out_pc",    bus.out_pc,         32'h300);
        check("recover out_rd",    32'(bus.out_rd),    32'd15);

        // Asynchronous reset mid-stream with two entries buffered
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_inst   = addi_rd(16);
        bus.in_pc     = 32'h400;
        repeat (2) @(negedge clk);
        bus.in_valid = 1'b0;
        check("prereset in_ready", 32'(bus.in_ready), 32'd0);
        #2 rst = 1'b0;
        #1;
        check("async reset out_valid", 32'(bus.out_valid), 32'd0);
        check("async reset in_ready",  32'(bus.in_ready),  32'd1);
        check("async reset out_pc",    bus.out_pc,         32'd0);
        @(negedge clk);
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("post reset out_valid", 32'(bus.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
